// File: rtl/scanning_spin_comparator.sv
// Time-multiplexed spin comparator: scans SPINS phase values LANES at a time and
// commits the full comparison vector and its popcount atomically at the end of a scan.
module scanning_spin_comparator #(
    parameter int WIDTH  = 32,
    parameter int SPINS  = 32,
    parameter int LANES  = 8,
    parameter int SIGNED = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       mode,
    input  logic                       ge_en,
    input  logic [WIDTH-1:0]           base,
    input  logic [SPINS*WIDTH-1:0]     values,
    input  logic [SPINS*WIDTH-1:0]     unrotated,
    input  logic [SPINS*WIDTH-1:0]     rotated,
    output logic                       busy,
    output logic                       done,
    output logic [SPINS-1:0]           comparison,
    output logic [$clog2(SPINS+1)-1:0] count
);
    localparam int G  = (SPINS + LANES - 1) / LANES;
    localparam int GW = (G > 1) ? $clog2(G) : 1;
    localparam int CW = $clog2(SPINS + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [GW-1:0]     grp_r;
    logic              mode_r;
    logic              ge_en_r;
    logic              signed_r;
    logic [WIDTH-1:0]  base_r;
    logic [SPINS-1:0]  shadow_r;
    logic [SPINS-1:0]  shadow_nxt_s;
    logic [SPINS-1:0]  comparison_r;
    logic [CW-1:0]     acc_r;
    logic [CW-1:0]     count_r;
    logic [CW-1:0]     part_s;
    logic [LANES-1:0]  lane_res_s;
    logic [LANES-1:0]  lane_ok_s;
    logic [WIDTH-1:0]  lane_lhs_s [LANES];
    logic [WIDTH-1:0]  lane_rhs_s [LANES];
    logic              accept_s;
    logic              last_grp_s;
    logic              busy_s;
    logic              done_s;

    // Clamp keeps masked-lane slice indices in range; those lanes are never selected.
    function automatic int spin_idx(input int g, input int l);
        int i;
        i = g * LANES + l;
        return (i < SPINS) ? i : (SPINS - 1);
    endfunction

    function automatic logic [CW-1:0] popcount_lanes(input logic [LANES-1:0] v);
        logic [CW-1:0] n;
        n = '0;
        for (int l = 0; l < LANES; l++) begin
            n = n + CW'(v[l]);
        end
        return n;
    endfunction

    assign accept_s   = start & ((state_r == ST_IDLE) | (state_r == ST_DONE));
    assign last_grp_s = (grp_r == GW'(G - 1));

    // Lane operand steering: pick the current group's spins per mode.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_ok_s[l]  = 1'b0;
            lane_lhs_s[l] = '0;
            lane_rhs_s[l] = '0;
            for (int g = 0; g < G; g++) begin
                if ((grp_r == GW'(g)) && ((g * LANES + l) < SPINS)) begin
                    lane_ok_s[l] = 1'b1;
                    if (mode_r) begin
                        lane_lhs_s[l] = rotated[spin_idx(g, l)*WIDTH +: WIDTH];
                        lane_rhs_s[l] = unrotated[spin_idx(g, l)*WIDTH +: WIDTH];
                    end else begin
                        lane_lhs_s[l] = values[spin_idx(g, l)*WIDTH +: WIDTH];
                        lane_rhs_s[l] = base_r;
                    end
                end else begin
                    lane_ok_s[l] = lane_ok_s[l];
                end
            end
        end
    end

    // Lane comparators plus shadow merge; masked lanes yield 0 and write nothing.
    always_comb begin
        lane_res_s   = '0;
        shadow_nxt_s = shadow_r;
        for (int l = 0; l < LANES; l++) begin
            if (signed_r) begin
                lane_res_s[l] = lane_ok_s[l] &
                    (($signed(lane_lhs_s[l]) > $signed(lane_rhs_s[l])) |
                     (ge_en_r & (lane_lhs_s[l] == lane_rhs_s[l])));
            end else begin
                lane_res_s[l] = lane_ok_s[l] &
                    ((lane_lhs_s[l] > lane_rhs_s[l]) |
                     (ge_en_r & (lane_lhs_s[l] == lane_rhs_s[l])));
            end
        end
        for (int s = 0; s < SPINS; s++) begin
            if (grp_r == GW'(s / LANES)) begin
                shadow_nxt_s[s] = lane_res_s[s % LANES];
            end else begin
                shadow_nxt_s[s] = shadow_r[s];
            end
        end
        part_s = popcount_lanes(lane_res_s);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; start during SCAN is ignored.
    always_comb begin
        state_nxt_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (start) state_nxt_s = ST_SCAN;
                else       state_nxt_s = ST_IDLE;
            end
            ST_SCAN: begin
                if (last_grp_s) state_nxt_s = ST_DONE;
                else            state_nxt_s = ST_SCAN;
            end
            ST_DONE: begin
                if (start) state_nxt_s = ST_SCAN;
                else       state_nxt_s = ST_IDLE;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Status decode from the state register.
    always_comb begin
        busy_s = 1'b0;
        done_s = 1'b0;
        case (state_r)
            ST_IDLE: begin busy_s = 1'b0; done_s = 1'b0; end
            ST_SCAN: begin busy_s = 1'b1; done_s = 1'b0; end
            ST_DONE: begin busy_s = 1'b0; done_s = 1'b1; end
            default: begin busy_s = 1'b0; done_s = 1'b0; end
        endcase
    end

    // Scan datapath: latch controls on accept, accumulate per group, commit at the last group.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grp_r        <= '0;
            mode_r       <= 1'b0;
            ge_en_r      <= 1'b0;
            signed_r     <= 1'b0;
            base_r       <= '0;
            shadow_r     <= '0;
            acc_r        <= '0;
            comparison_r <= '0;
            count_r      <= '0;
        end else if (accept_s) begin
            grp_r    <= '0;
            mode_r   <= mode;
            ge_en_r  <= ge_en;
            signed_r <= (SIGNED != 0);
            base_r   <= base;
            shadow_r <= '0;
            acc_r    <= '0;
        end else if (state_r == ST_SCAN) begin
            shadow_r <= shadow_nxt_s;
            acc_r    <= acc_r + part_s;
            if (last_grp_s) begin
                grp_r        <= '0;
                comparison_r <= shadow_nxt_s;
                count_r      <= acc_r + part_s;
            end else begin
                grp_r <= grp_r + GW'(1);
            end
        end else begin
            grp_r <= grp_r;
        end
    end

    assign busy       = busy_s;
    assign done       = done_s;
    assign comparison = comparison_r;
    assign count      = count_r;

endmodule

// File: tb/tb_scanning_spin_comparator.sv
// Scoreboard bench: several configurations share one stimulus stream; each has its own
// reference model (queue of expected results) and a negedge monitor.
module tb_scanning_spin_comparator;
    localparam int NI = 4;

    function automatic int sp_of(input int k);
        case (k)
            0: return 32;
            1: return 32;
            2: return 20;
            default: return 8;
        endcase
    endfunction

    function automatic int sg_of(input int k);
        return (k == 1) ? 1 : 0;
    endfunction

    typedef struct {
        logic [31:0] cmp;
        int          cnt;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          mode = 1'b0;
    logic          ge_en = 1'b0;
    logic [31:0]   base = '0;
    logic [1023:0] values = '0;
    logic [1023:0] unrot = '0;
    logic [1023:0] rot = '0;
    int            total = 0;
    int            bad = 0;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 50) $display("FAIL %s inst%0d actual=%h required=%h", nm, k, act, exp);
        end
    endtask

    // Reference: compare every spin with plain integer arithmetic.
    function automatic void ref_model(input int s, input bit sg, input bit md, input bit ge,
                                      input logic [31:0] b, input logic [1023:0] v,
                                      input logic [1023:0] r, input logic [1023:0] u,
                                      output logic [31:0] c, output int n);
        logic [31:0] lhs, rhs;
        longint      a, bb;
        bit          hit;
        c = '0;
        n = 0;
        for (int i = 0; i < s; i++) begin
            if (md) begin lhs = r[i*32 +: 32]; rhs = u[i*32 +: 32]; end
            else begin lhs = v[i*32 +: 32]; rhs = b; end
            if (sg) begin a = longint'($signed(lhs)); bb = longint'($signed(rhs)); end
            else begin a = longint'({32'd0, lhs}); bb = longint'({32'd0, rhs}); end
            hit = ge ? (a >= bb) : (a > bb);
            c[i] = hit;
            n += int'(hit);
        end
    endfunction

    for (genvar k = 0; k < NI; k++) begin : g_inst
        localparam int S   = sp_of(k);
        localparam int L   = 8;
        localparam int G   = (S + L - 1) / L;
        localparam int CWK = $clog2(S + 1);

        logic           busy;
        logic           done;
        logic [S-1:0]   comparison;
        logic [CWK-1:0] count;

        scanning_spin_comparator #(
            .WIDTH(32), .SPINS(S), .LANES(L), .SIGNED(sg_of(k))
        ) u_dut (
            .clk(clk), .rst(rst), .start(start), .mode(mode), .ge_en(ge_en), .base(base),
            .values(values[S*32-1:0]), .unrotated(unrot[S*32-1:0]), .rotated(rot[S*32-1:0]),
            .busy(busy), .done(done), .comparison(comparison), .count(count)
        );

        exp_t        q[$];
        longint      ec = 0;
        longint      e0 = -1000;
        logic [31:0] held_cmp = '0;
        int          held_cnt = 0;
        bit          exp_busy;
        bit          exp_done;

        // Model: a start is taken once the previous scan has reached its done cycle.
        initial forever begin
            exp_t e;
            @(posedge clk or posedge rst);
            if (rst) begin
                q.delete();
                e0 = -1000;
                held_cmp = '0;
                held_cnt = 0;
            end else begin
                ec++;
                if (start && (ec >= e0 + G + 1)) begin
                    e0 = ec;
                    ref_model(S, sg_of(k) != 0, mode, ge_en, base, values, rot, unrot, e.cmp, e.cnt);
                    q.push_back(e);
                end
            end
        end

        // Monitor: status every cycle; results commit and then hold.
        initial forever begin
            exp_t e;
            @(negedge clk);
            exp_busy = (ec >= e0) && (ec < e0 + G);
            exp_done = (ec == e0 + G);
            if (exp_done) begin
                chk("queue_nonempty", k, 32'(q.size() > 0), 32'd1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    held_cmp = e.cmp;
                    held_cnt = e.cnt;
                end
            end
            chk("busy", k, 32'(busy), 32'(exp_busy));
            chk("done", k, 32'(done), 32'(exp_done));
            chk("comparison", k, 32'(comparison), 32'(held_cmp[S-1:0]));
            chk("count", k, 32'(count), 32'(held_cnt));
        end
    end

    task automatic run_scan(input bit m, input bit g);
        @(negedge clk);
        mode = m;
        ge_en = g;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic rand_ops(input int eq_odds);
        base = $urandom();
        for (int i = 0; i < 32; i++) begin
            values[i*32 +: 32] = ($urandom_range(0, eq_odds) == 0) ? base : $urandom();
            unrot[i*32 +: 32]  = $urandom();
            rot[i*32 +: 32]    = ($urandom_range(0, eq_odds) == 0) ? unrot[i*32 +: 32] : $urandom();
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_cmp", 0, 32'(g_inst[0].comparison), 32'd0);
        chk("reset_busy", 0, 32'(g_inst[0].busy), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Ramp 3*i against 40.
        base = 32'd40;
        for (int i = 0; i < 32; i++) values[i*32 +: 32] = 32'(3 * i);
        run_scan(1'b0, 1'b0);
        chk("t1_cmp", 0, 32'(g_inst[0].comparison), 32'hFFFF_C000);
        chk("t1_cnt", 0, 32'(g_inst[0].count), 32'd18);

        // Equal POST operands, strict then inclusive.
        for (int i = 0; i < 32; i++) begin
            unrot[i*32 +: 32] = $urandom();
            rot[i*32 +: 32]   = unrot[i*32 +: 32];
        end
        run_scan(1'b1, 1'b0);
        chk("t2_gt_cmp", 0, 32'(g_inst[0].comparison), 32'd0);
        run_scan(1'b1, 1'b1);
        chk("t2_ge_cmp", 0, 32'(g_inst[0].comparison), 32'hFFFF_FFFF);
        chk("t2_ge_cnt", 0, 32'(g_inst[0].count), 32'd32);

        // All-ones value: large unsigned, -1 signed.
        base = 32'd0;
        values = '0;
        values[31:0] = 32'hFFFF_FFFF;
        run_scan(1'b0, 1'b0);
        chk("t3_uns_cmp", 0, 32'(g_inst[0].comparison), 32'd1);
        chk("t3_sgn_cmp", 1, 32'(g_inst[1].comparison), 32'd0);

        // Partial last group on the 20-spin instance.
        base = 32'd4;
        for (int i = 0; i < 32; i++) values[i*32 +: 32] = 32'd5;
        run_scan(1'b0, 1'b0);
        chk("t4_cmp", 2, 32'(g_inst[2].comparison), 32'h000F_FFFF);
        chk("t4_cnt", 2, 32'(g_inst[2].count), 32'd20);

        // Random scans.
        for (int t = 0; t < 25; t++) begin
            rand_ops(3);
            run_scan(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Back-to-back with start held, then random start pulses during scans.
        rand_ops(2);
        @(negedge clk);
        mode = 1'b0;
        ge_en = 1'b1;
        start = 1'b1;
        repeat (14) @(negedge clk);
        for (int t = 0; t < 20; t++) begin
            start = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        start = 1'b0;
        repeat (6) @(negedge clk);

        // Reset two cycles into a scan, after a known 0xFFFF0000 result.
        base = 32'd50;
        for (int i = 0; i < 32; i++) values[i*32 +: 32] = (i >= 16) ? 32'd100 : 32'd0;
        run_scan(1'b0, 1'b0);
        chk("t6_prior", 0, 32'(g_inst[0].comparison), 32'hFFFF_0000);
        for (int i = 0; i < 32; i++) values[i*32 +: 32] = 32'd100;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #2;
        chk("t6_rst_cmp", 0, 32'(g_inst[0].comparison), 32'd0);
        chk("t6_rst_cnt", 0, 32'(g_inst[0].count), 32'd0);
        chk("t6_rst_busy", 0, 32'(g_inst[0].busy), 32'd0);
        chk("t6_rst_done", 0, 32'(g_inst[0].done), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 32; i++) values[i*32 +: 32] = (i >= 16) ? 32'd100 : 32'd0;
        run_scan(1'b0, 1'b0);
        chk("t6_fresh", 0, 32'(g_inst[0].comparison), 32'hFFFF_0000);
        chk("t6_fresh_cnt", 0, 32'(g_inst[0].count), 32'd16);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
